// File: rtl/proc_mc_pkg.sv
// Shared definitions for the parametrised multicycle processor: opcodes,
// controller states and the register-index width helper.
package proc_mc_pkg;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_MVNZ = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EX1,
        S_EX2,
        S_EX3
    } state_t;

    function automatic int reg_w(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/proc_mc_core_regfile.sv
// General register file; the top register doubles as the program counter and
// has its own increment input, which a same-cycle write overrides.
module proc_regfile
    import proc_mc_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    localparam int REG_W  = reg_w(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pc_inc,
    input  logic [REG_W-1:0]  i_rx_addr,
    input  logic [REG_W-1:0]  i_ry_addr,
    output logic [DATA_W-1:0] o_rx_data,
    output logic [DATA_W-1:0] o_ry_data,
    output logic [DATA_W-1:0] o_pc
);

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (i_pc_inc) begin
                r_regs[NREG-1] <= r_regs[NREG-1] + DATA_W'(1);
            end
            // Issued after the increment so a jump or immediate load of the PC wins.
            if (i_we) begin
                r_regs[i_waddr] <= i_wdata;
            end
        end
    end

    assign o_rx_data = r_regs[i_rx_addr];
    assign o_ry_data = r_regs[i_ry_addr];
    assign o_pc      = r_regs[NREG-1];

endmodule

// File: rtl/proc_mc_core.sv
// Run-driven multicycle processor that fetches its own instructions and data
// over a req/ack memory port; R[NREG-1] is the program counter.
module proc_mc_core
    import proc_mc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] pc_dbg
);

    localparam int REG_W = reg_w(NREG);
    localparam int IR_W  = 3 + 2 * REG_W;

    state_t            r_state;
    state_t            w_next;
    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    logic [DATA_W-1:0] r_mar;
    logic              r_z;
    logic              r_done;

    logic [2:0]        w_op;
    logic [REG_W-1:0]  w_rx;
    logic [REG_W-1:0]  w_ry;
    logic [DATA_W-1:0] w_rx_data;
    logic [DATA_W-1:0] w_ry_data;
    logic [DATA_W-1:0] w_pc;
    logic [DATA_W-1:0] w_alu;

    logic              w_req;
    logic              w_we;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;
    logic              w_pc_inc;
    logic              w_retire;
    logic              w_ir_ld;
    logic              w_a_ld;
    logic              w_g_ld;
    logic              w_mar_ld;

    function automatic logic [DATA_W-1:0] alu(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a + b;
        endcase
    endfunction

    assign w_op  = r_ir[IR_W-1 -: 3];
    assign w_rx  = r_ir[2*REG_W-1 -: REG_W];
    assign w_ry  = r_ir[REG_W-1:0];
    assign w_alu = alu(w_op, r_a, w_ry_data);

    proc_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clock     (clock),
        .reset     (reset),
        .i_we      (w_rf_we),
        .i_waddr   (w_rx),
        .i_wdata   (w_rf_wdata),
        .i_pc_inc  (w_pc_inc),
        .i_rx_addr (w_rx),
        .i_ry_addr (w_ry),
        .o_rx_data (w_rx_data),
        .o_ry_data (w_ry_data),
        .o_pc      (w_pc)
    );

    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_we       = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_rf_we    = 1'b0;
        w_rf_wdata = w_ry_data;
        w_pc_inc   = 1'b0;
        w_retire   = 1'b0;
        w_ir_ld    = 1'b0;
        w_a_ld     = 1'b0;
        w_g_ld     = 1'b0;
        w_mar_ld   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = w_pc;
                if (mem_ack) begin
                    w_ir_ld  = 1'b1;
                    w_pc_inc = 1'b1;
                    w_next   = S_EX1;
                end
            end
            S_EX1: begin
                case (w_op)
                    OP_MV: begin
                        w_rf_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                    OP_MVNZ: begin
                        w_rf_we  = !r_z;
                        w_retire = 1'b1;
                    end
                    OP_ST: begin
                        w_req    = 1'b1;
                        w_we     = 1'b1;
                        w_addr   = w_ry_data;
                        w_wdata  = w_rx_data;
                        w_retire = mem_ack;
                    end
                    // Reads latch their address first so the bus address comes from a register.
                    OP_MVI, OP_LD: begin
                        w_mar_ld = 1'b1;
                        w_next   = S_EX2;
                    end
                    default: begin
                        w_a_ld = 1'b1;
                        w_next = S_EX2;
                    end
                endcase
            end
            S_EX2: begin
                case (w_op)
                    OP_MVI, OP_LD: begin
                        w_req  = 1'b1;
                        w_addr = r_mar;
                        if (mem_ack) begin
                            w_rf_we    = 1'b1;
                            w_rf_wdata = mem_rdata;
                            w_pc_inc   = (w_op == OP_MVI);
                            w_retire   = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_g_ld = 1'b1;
                        w_next = S_EX3;
                    end
                    default: begin
                        w_next = S_IDLE;
                    end
                endcase
            end
            S_EX3: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_g;
                w_retire   = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_retire) begin
            w_next = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_mar   <= '0;
            r_z     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_retire;
            if (w_ir_ld) begin
                r_ir <= mem_rdata[IR_W-1:0];
            end
            if (w_a_ld) begin
                r_a <= w_rx_data;
            end
            if (w_g_ld) begin
                r_g <= w_alu;
                r_z <= (w_alu == '0);
            end
            if (w_mar_ld) begin
                r_mar <= (w_op == OP_MVI) ? w_pc : w_ry_data;
            end
        end
    end

    if (ADDR_W <= DATA_W) begin : g_addr_trunc
        assign mem_addr = w_addr[ADDR_W-1:0];
    end else begin : g_addr_ext
        assign mem_addr = {{(ADDR_W-DATA_W){1'b0}}, w_addr};
    end

    assign mem_req   = w_req;
    assign mem_we    = w_we;
    assign mem_wdata = w_wdata;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign pc_dbg    = w_pc;

endmodule
